uart_rx_oversample: RTL and testbench

//   Stand-alone UART receiver, 8N1, LSB first, with oversampled start/bit detection and 3-sample majority vote.

---
 rtl/uart_rx_oversample.sv | 141 ++++++++++++++
 tb/tb_uart_rx_oversample.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversample.sv
`timescale 1ns/1ps
// UART 8N1 receiver: 2-FF input sync, fractional oversample tick, 3-sample majority per bit.
// Emits one-clk Done / Frame_Err pulses; a line held low (break) yields a single error.
module uart_rx_oversample #(
  parameter int unsigned CLOCK_RATE    = 25000000,
  parameter int unsigned BAUD_RATE     = 115200,
  parameter int unsigned RX_OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_Rx_Data,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Done,
  output logic       o_Rx_Busy,
  output logic       o_Frame_Err
);
  localparam int unsigned   TW       = $clog2(RX_OVERSAMPLE);
  localparam logic [31:0]   ACC_INC  = 32'(BAUD_RATE * RX_OVERSAMPLE);
  localparam logic [31:0]   ACC_MOD  = 32'(CLOCK_RATE);
  localparam logic [TW-1:0] IDX_LO   = TW'(RX_OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] IDX_MID  = TW'(RX_OVERSAMPLE / 2);
  localparam logic [TW-1:0] IDX_HI   = TW'(RX_OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] IDX_LAST = TW'(RX_OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  state_t state, state_nxt;

  logic          rx_meta, rx_s, rx_prev;
  logic [31:0]   acc, acc_sum;
  logic          tick;
  logic [TW-1:0] tick_cnt;
  logic [2:0]    bit_cnt;
  logic          s_lo, s_mid;
  logic [7:0]    shreg;
  logic          start_edge, at_lo, at_mid, at_hi, at_last, maj;
  logic          done_nxt, err_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= i_Rx_Data;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign start_edge = (state == IDLE) && rx_prev && !rx_s;
  assign acc_sum    = acc + ACC_INC;

  // Fractional accumulator: average tick rate is exact; cleared on the start edge to phase-align bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc  <= '0;
      tick <= 1'b0;
    end else if (start_edge) begin
      acc  <= '0;
      tick <= 1'b0;
    end else if (acc_sum >= ACC_MOD) begin
      acc  <= acc_sum - ACC_MOD;
      tick <= 1'b1;
    end else begin
      acc  <= acc_sum;
      tick <= 1'b0;
    end
  end

  assign at_lo   = tick && (tick_cnt == IDX_LO);
  assign at_mid  = tick && (tick_cnt == IDX_MID);
  assign at_hi   = tick && (tick_cnt == IDX_HI);
  assign at_last = tick && (tick_cnt == IDX_LAST);
  // Third sample is taken live at the IDX_HI tick, so the vote is ready on that same cycle.
  assign maj     = (s_lo & s_mid) | (s_lo & rx_s) | (s_mid & rx_s);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
      s_lo     <= 1'b0;
      s_mid    <= 1'b0;
      shreg    <= '0;
    end else begin
      if (start_edge)   tick_cnt <= '0;
      else if (at_last) tick_cnt <= '0;
      else if (tick)    tick_cnt <= tick_cnt + TW'(1);

      if (start_edge)                    bit_cnt <= '0;
      else if (state == DATA && at_last) bit_cnt <= bit_cnt + 3'd1;

      if (at_lo)  s_lo  <= rx_s;
      if (at_mid) s_mid <= rx_s;

      if (state == DATA && at_hi) shreg <= {maj, shreg[7:1]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start_edge) state_nxt = START;
      START: begin
        if (at_hi && maj) state_nxt = IDLE;
        else if (at_last) state_nxt = DATA;
      end
      DATA:  if (at_last && bit_cnt == 3'd7) state_nxt = STOP;
      STOP:  if (at_hi) state_nxt = maj ? IDLE : BREAK;
      BREAK: if (rx_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    done_nxt = 1'b0;
    err_nxt  = 1'b0;
    if (state == STOP && at_hi) begin
      done_nxt = maj;
      err_nxt  = !maj;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_Rx_Byte   <= 8'h00;
      o_Rx_Done   <= 1'b0;
      o_Frame_Err <= 1'b0;
      o_Rx_Busy   <= 1'b0;
    end else begin
      o_Rx_Done   <= done_nxt;
      o_Frame_Err <= err_nxt;
      o_Rx_Busy   <= (state_nxt != IDLE);
      if (done_nxt) o_Rx_Byte <= shreg;
    end
  end
endmodule

// File: tb/tb_uart_rx_oversample.sv
`timescale 1ns/1ps
// Bench for uart_rx_oversample: bit-accurate serializer, pulse monitor and byte-level reference model.
module tb_uart_rx_oversample;
  localparam int BIT = 8680;

  logic       clk;
  logic       reset_n;
  logic       i_Rx_Data;
  logic [7:0] o_Rx_Byte;
  logic       o_Rx_Done;
  logic       o_Rx_Busy;
  logic       o_Frame_Err;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int both_cnt = 0;
  int wide_cnt = 0;
  logic done_d = 1'b0;
  logic err_d  = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] model_byte;

  uart_rx_oversample dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_Rx_Data   (i_Rx_Data),
    .o_Rx_Byte   (o_Rx_Byte),
    .o_Rx_Done   (o_Rx_Done),
    .o_Rx_Busy   (o_Rx_Busy),
    .o_Frame_Err (o_Frame_Err)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  // Pulse monitor: counts pulses and captures every delivered byte.
  always @(negedge clk) begin
    if (o_Rx_Done) begin
      done_cnt <= done_cnt + 1;
      got_q.push_back(o_Rx_Byte);
    end
    if (o_Frame_Err) err_cnt <= err_cnt + 1;
    if (o_Rx_Done && o_Frame_Err) both_cnt <= both_cnt + 1;
    if ((o_Rx_Done && done_d) || (o_Frame_Err && err_d)) wide_cnt <= wide_cnt + 1;
    done_d <= o_Rx_Done;
    err_d  <= o_Frame_Err;
  end

  // Driver: start bit, 8 data bits LSB first, stop bit; line is left at the stop value.
  task automatic send_frame(input logic [7:0] b, input int bit_ns, input logic stop);
    i_Rx_Data = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      i_Rx_Data = b[i];
      #(bit_ns);
    end
    i_Rx_Data = stop;
    #(bit_ns);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (o_Rx_Busy !== 1'b0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (o_Rx_Busy !== 1'b0) begin
      n_errors++;
      $display("FAIL %s busy_timeout: got busy=%b want 0", name, o_Rx_Busy);
    end
  endtask

  task automatic test_reset;
    reset_n   = 1'b0;
    i_Rx_Data = 1'b1;
    repeat (5) @(negedge clk);
    n_checks += 4;
    if (o_Rx_Byte !== 8'h00) begin n_errors++; $display("FAIL reset_byte: got %h want 00", o_Rx_Byte); end
    if (o_Rx_Done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b want 0", o_Rx_Done); end
    if (o_Rx_Busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", o_Rx_Busy); end
    if (o_Frame_Err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b want 0", o_Frame_Err); end
    reset_n = 1'b1;
    model_byte = 8'h00;
    #(2 * BIT);
  endtask

  task automatic test_single;
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'h55, BIT, 1'b1);
    model_byte = 8'h55;
    #(BIT);
    wait_idle("single");
    n_checks += 3;
    if (done_cnt - d0 != 1) begin n_errors++; $display("FAIL single_done_count: got %0d want 1", done_cnt - d0); end
    if (err_cnt - e0 != 0) begin n_errors++; $display("FAIL single_err_count: got %0d want 0", err_cnt - e0); end
    if (o_Rx_Byte !== model_byte) begin n_errors++; $display("FAIL single_byte: got %h want %h", o_Rx_Byte, model_byte); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] frames[3];
    frames[0] = 8'h01; frames[1] = 8'hAA; frames[2] = 8'hFF;
    exp_q.delete(); got_q.delete();
    foreach (frames[i]) begin
      send_frame(frames[i], BIT, 1'b1);
      exp_q.push_back(frames[i]);
      model_byte = frames[i];
    end
    #(BIT);
    wait_idle("b2b");
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_errors++;
      $display("FAIL b2b_count: got %0d frames want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL b2b_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_glitch;
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    i_Rx_Data = 1'b0;
    #1000;
    n_checks++;
    if (o_Rx_Busy !== 1'b1) begin n_errors++; $display("FAIL glitch_busy_seen: got %b want 1", o_Rx_Busy); end
    #1000;
    i_Rx_Data = 1'b1;
    #(BIT - 2000);
    n_checks += 3;
    if (o_Rx_Busy !== 1'b0) begin n_errors++; $display("FAIL glitch_busy_clear: got %b want 0", o_Rx_Busy); end
    if (done_cnt - d0 != 0) begin n_errors++; $display("FAIL glitch_done: got %0d want 0", done_cnt - d0); end
    if (err_cnt - e0 != 0) begin n_errors++; $display("FAIL glitch_err: got %0d want 0", err_cnt - e0); end
    send_frame(8'h3C, BIT, 1'b1);
    model_byte = 8'h3C;
    #(BIT);
    wait_idle("glitch_follow");
    n_checks += 2;
    if (done_cnt - d0 != 1) begin n_errors++; $display("FAIL glitch_follow_done: got %0d want 1", done_cnt - d0); end
    if (o_Rx_Byte !== model_byte) begin n_errors++; $display("FAIL glitch_follow_byte: got %h want %h", o_Rx_Byte, model_byte); end
  endtask

  task automatic test_break;
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'hA5, BIT, 1'b0);
    #(2 * BIT);
    i_Rx_Data = 1'b1;
    #(2 * BIT);
    wait_idle("break");
    n_checks += 3;
    if (err_cnt - e0 != 1) begin n_errors++; $display("FAIL break_err_count: got %0d want 1", err_cnt - e0); end
    if (done_cnt - d0 != 0) begin n_errors++; $display("FAIL break_done_count: got %0d want 0", done_cnt - d0); end
    if (o_Rx_Byte !== model_byte) begin n_errors++; $display("FAIL break_byte_held: got %h want %h", o_Rx_Byte, model_byte); end
  endtask

  task automatic test_reset_mid_frame;
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    fork
      send_frame(8'h96, BIT, 1'b1);
      begin
        #(BIT * 11 / 2 + 7);
        reset_n = 1'b0;
        #200;
        n_checks += 4;
        if (o_Rx_Byte !== 8'h00) begin n_errors++; $display("FAIL midreset_byte: got %h want 00", o_Rx_Byte); end
        if (o_Rx_Done !== 1'b0) begin n_errors++; $display("FAIL midreset_done: got %b want 0", o_Rx_Done); end
        if (o_Rx_Busy !== 1'b0) begin n_errors++; $display("FAIL midreset_busy: got %b want 0", o_Rx_Busy); end
        if (o_Frame_Err !== 1'b0) begin n_errors++; $display("FAIL midreset_err: got %b want 0", o_Frame_Err); end
        #(5 * BIT);
        reset_n = 1'b1;
      end
    join
    model_byte = 8'h00;
    #(BIT);
    n_checks += 2;
    if (done_cnt - d0 != 0) begin n_errors++; $display("FAIL midreset_no_done: got %0d want 0", done_cnt - d0); end
    if (err_cnt - e0 != 0) begin n_errors++; $display("FAIL midreset_no_err: got %0d want 0", err_cnt - e0); end
    send_frame(8'h69, BIT, 1'b1);
    model_byte = 8'h69;
    #(BIT);
    wait_idle("midreset_follow");
    n_checks += 2;
    if (done_cnt - d0 != 1) begin n_errors++; $display("FAIL midreset_follow_done: got %0d want 1", done_cnt - d0); end
    if (o_Rx_Byte !== model_byte) begin n_errors++; $display("FAIL midreset_follow_byte: got %h want %h", o_Rx_Byte, model_byte); end
  endtask

  task automatic test_baud_tolerance;
    int rates[2];
    int d0;
    rates[0] = 1000000000 / 118656;
    rates[1] = 1000000000 / 111744;
    foreach (rates[i]) begin
      d0 = done_cnt;
      send_frame(8'hC3, rates[i], 1'b1);
      model_byte = 8'hC3;
      #(BIT);
      wait_idle("baud");
      n_checks += 2;
      if (done_cnt - d0 != 1) begin n_errors++; $display("FAIL baud%0d_done: got %0d want 1", rates[i], done_cnt - d0); end
      if (o_Rx_Byte !== model_byte) begin n_errors++; $display("FAIL baud%0d_byte: got %h want %h", rates[i], o_Rx_Byte, model_byte); end
    end
  endtask

  // Random bytes, bit periods within +/-2%, occasional bad stop bit; model tracks good bytes and errors.
  task automatic test_random;
    int e0, exp_err, bit_ns;
    logic [7:0] b;
    logic bad;
    exp_q.delete(); got_q.delete();
    e0 = err_cnt; exp_err = 0;
    for (int k = 0; k < 8; k++) begin
      b      = 8'($urandom_range(0, 255));
      bad    = ($urandom_range(0, 3) == 0);
      bit_ns = $urandom_range(8510, 8850);
      send_frame(b, bit_ns, !bad);
      if (bad) begin
        exp_err++;
        i_Rx_Data = 1'b1;
        #(BIT);
      end else begin
        exp_q.push_back(b);
        model_byte = b;
        if ($urandom_range(0, 1) == 1) #(BIT);
      end
    end
    #(BIT);
    wait_idle("random");
    n_checks += 3;
    if (got_q.size() != exp_q.size()) begin n_errors++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    if (err_cnt - e0 != exp_err) begin n_errors++; $display("FAIL rand_err_count: got %0d want %0d", err_cnt - e0, exp_err); end
    if (o_Rx_Byte !== model_byte) begin n_errors++; $display("FAIL rand_last_byte: got %h want %h", o_Rx_Byte, model_byte); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL rand_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_pulse_shape;
    n_checks += 2;
    if (both_cnt != 0) begin n_errors++; $display("FAIL done_err_overlap: got %0d cycles want 0", both_cnt); end
    if (wide_cnt != 0) begin n_errors++; $display("FAIL pulse_width: got %0d wide pulses want 0", wide_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_break();
    test_reset_mid_frame();
    test_baud_tolerance();
    test_random();
    test_pulse_shape();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
